// File: rtl/id_ex_decode.sv
// RV32I decode stage with ID/EX pipeline register: valid/ready handshake,
// load-use interlock, flush and a saturating load-use stall counter.
module id_ex_decode #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [5:0]             alu_control,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [31:0]            imm,
    output logic                   use_imm,
    output logic                   reg_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   branch,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] ALU_ADD    = 6'd1;
    localparam logic [5:0] ALU_SUB    = 6'd2;
    localparam logic [5:0] ALU_AND    = 6'd3;
    localparam logic [5:0] ALU_OR     = 6'd4;
    localparam logic [5:0] ALU_XOR    = 6'd5;
    localparam logic [5:0] ALU_SLL    = 6'd6;
    localparam logic [5:0] ALU_SRL    = 6'd7;
    localparam logic [5:0] ALU_SRA    = 6'd8;
    localparam logic [5:0] ALU_SLT    = 6'd9;
    localparam logic [5:0] ALU_ADDI   = 6'd10;
    localparam logic [5:0] ALU_ANDI   = 6'd11;
    localparam logic [5:0] ALU_ORI    = 6'd12;
    localparam logic [5:0] ALU_XORI   = 6'd13;
    localparam logic [5:0] ALU_SLTI   = 6'd14;
    localparam logic [5:0] ALU_SLLI   = 6'd15;
    localparam logic [5:0] ALU_SRLI   = 6'd16;
    localparam logic [5:0] ALU_L_WORD = 6'd17;
    localparam logic [5:0] ALU_S_WORD = 6'd18;
    localparam logic [5:0] ALU_BEQ    = 6'd19;
    localparam logic [5:0] ALU_BNE    = 6'd20;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [5:0]  w_alu;
    logic [31:0] w_imm;
    logic        w_use_imm;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_illegal;
    logic        w_uses_rs2;
    logic        w_hazard;
    logic        w_accept;

    logic                   r_out_valid;
    logic [5:0]             r_alu;
    logic [4:0]             r_rs1;
    logic [4:0]             r_rs2;
    logic [4:0]             r_rd;
    logic [31:0]            r_imm;
    logic                   r_use_imm;
    logic                   r_reg_write;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic                   r_branch;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_stall;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_f3     = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_f7     = in_instr[31:25];

    always_comb begin
        w_alu       = '0;
        w_imm       = '0;
        w_use_imm   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        w_uses_rs2  = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_reg_write = 1'b1;
                w_uses_rs2  = 1'b1;
                case ({w_f7, w_f3})
                    {7'h00, 3'b000}: w_alu = ALU_ADD;
                    {7'h20, 3'b000}: w_alu = ALU_SUB;
                    {7'h00, 3'b111}: w_alu = ALU_AND;
                    {7'h00, 3'b110}: w_alu = ALU_OR;
                    {7'h00, 3'b100}: w_alu = ALU_XOR;
                    {7'h00, 3'b001}: w_alu = ALU_SLL;
                    {7'h00, 3'b101}: w_alu = ALU_SRL;
                    {7'h20, 3'b101}: w_alu = ALU_SRA;
                    {7'h00, 3'b010}: w_alu = ALU_SLT;
                    default:         w_illegal = 1'b1;
                endcase
            end
            OP_I: begin
                w_reg_write = 1'b1;
                w_use_imm   = 1'b1;
                w_imm       = {{20{in_instr[31]}}, in_instr[31:20]};
                case (w_f3)
                    3'b000: w_alu = ALU_ADDI;
                    3'b111: w_alu = ALU_ANDI;
                    3'b110: w_alu = ALU_ORI;
                    3'b100: w_alu = ALU_XORI;
                    3'b010: w_alu = ALU_SLTI;
                    3'b001, 3'b101: begin
                        // shifts take a zero-extended shamt; only funct7==0 forms are supported
                        w_imm = {27'd0, in_instr[24:20]};
                        if (w_f7 != 7'h00)
                            w_illegal = 1'b1;
                        else
                            w_alu = (w_f3 == 3'b001) ? ALU_SLLI : ALU_SRLI;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_alu       = ALU_L_WORD;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
                w_use_imm   = 1'b1;
                w_imm       = {{20{in_instr[31]}}, in_instr[31:20]};
                if (w_f3 != 3'b010)
                    w_illegal = 1'b1;
            end
            OP_STORE: begin
                w_uses_rs2  = 1'b1;
                w_alu       = ALU_S_WORD;
                w_mem_write = 1'b1;
                w_use_imm   = 1'b1;
                w_imm       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                if (w_f3 != 3'b010)
                    w_illegal = 1'b1;
            end
            OP_BRANCH: begin
                w_uses_rs2 = 1'b1;
                w_branch   = 1'b1;
                w_imm      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
                case (w_f3)
                    3'b000:  w_alu = ALU_BEQ;
                    3'b001:  w_alu = ALU_BNE;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_alu       = '0;
            w_imm       = '0;
            w_use_imm   = 1'b0;
            w_reg_write = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_branch    = 1'b0;
        end
        if (w_rd == 5'd0)
            w_reg_write = 1'b0;
    end

    assign w_hazard = r_out_valid & r_mem_read & (r_rd != 5'd0) &
                      ((r_rd == w_rs1) | (w_uses_rs2 & (r_rd == w_rs2)));
    assign in_ready = (~r_out_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_alu       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
            r_stall     <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_alu       <= w_alu;
                r_rs1       <= w_rs1;
                r_rs2       <= w_rs2;
                r_rd        <= w_rd;
                r_imm       <= w_imm;
                r_use_imm   <= w_use_imm;
                r_reg_write <= w_reg_write;
                r_mem_read  <= w_mem_read;
                r_mem_write <= w_mem_write;
                r_branch    <= w_branch;
                r_illegal   <= w_illegal;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_hazard & in_valid & ~flush & ~(&r_stall))
                r_stall <= r_stall + 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign alu_control = r_alu;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign imm         = r_imm;
    assign use_imm     = r_use_imm;
    assign reg_write   = r_reg_write;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign branch      = r_branch;
    assign illegal     = r_illegal;
    assign stall_count = r_stall;

endmodule
